// File: rtl/pci_fifo_pkg.sv
// Definitions shared by the PCI datapath FIFO read-side drainer and the master engine.
package pci_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } drain_state_t;

    localparam int unsigned DRAIN_BURST_MAX = 8;
    localparam int unsigned DRAIN_TIMEOUT   = 64;

    // Width that holds every burst length 0..burst_max.
    function automatic int unsigned len_width(input int unsigned burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry valid/ready output buffer; reports how many more words may be
// launched towards it so that a one-cycle-latency source never overruns it.
module fifo_out_skid #(
    parameter int unsigned DSIZE = 32
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       credit
);

    logic [DSIZE-1:0] data_q [2];
    logic [DSIZE-1:0] data_d [2];
    logic [1:0]       count_q, count_d;
    logic             deq;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[0];
    assign deq       = out_valid & out_ready;

    // The word arriving now already owns a slot; the word leaving now frees one.
    assign credit = 2'd2 - count_q - {1'b0, in_valid} + {1'b0, deq};

    always_comb begin
        // NOTE: every *_d starts from its held value so no path leaves it unassigned (no latch).
        data_d  = data_q;
        count_d = count_q;
        unique case ({in_valid, deq})
            2'b10: begin
                data_d[count_q[0]] = in_data;
                count_d            = count_q + 2'd1;
            end
            2'b01: begin
                data_d[0] = data_q[1];
                count_d   = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    data_d[0] = in_data;
                end else begin
                    data_d[0] = data_q[1];
                    data_d[1] = in_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: storage is reset as well, because out_data must read zero out of reset.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            count_q <= 2'd0;
            data_q  <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Read-side burst drainer: decides when to empty the async FIFO, requests a bus
// burst, then streams exactly the latched number of words to the master engine.
module fifo_burst_drain
    import pci_fifo_pkg::*;
#(
    parameter  int unsigned DSIZE     = 32,
    parameter  int unsigned ASIZE     = 4,
    parameter  int unsigned BURST_MAX = DRAIN_BURST_MAX,
    parameter  int unsigned TIMEOUT   = DRAIN_TIMEOUT,
    localparam int unsigned LW        = len_width(BURST_MAX)
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic [DSIZE-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic [ASIZE:0]   fifo_rd_count,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             req,
    output logic [LW-1:0]    req_len,
    input  logic             gnt,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy
);

    localparam int unsigned    TW        = $clog2(TIMEOUT);
    localparam logic [ASIZE:0] BURST_CNT = (ASIZE + 1)'(BURST_MAX);
    localparam logic [LW-1:0]  BURST_LEN = LW'(BURST_MAX);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT - 1);

    drain_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] dlv_q, dlv_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    credit;
    logic          full_burst, launch, deq;
    logic [LW-1:0] launch_len;

    fifo_out_skid #(.DSIZE(DSIZE)) u_skid (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .in_valid  (inflight_q),
        .in_data   (fifo_dout),
        .out_data  (m_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .credit    (credit)
    );

    // Priority (full, timeout, flush) only matters for len, which full_burst selects.
    assign full_burst = (fifo_rd_count >= BURST_CNT);
    assign launch     = full_burst ||
                        ((fifo_rd_count != '0) && ((timer_q == TIMER_MAX) || flush));
    assign launch_len = full_burst ? BURST_LEN : LW'(fifo_rd_count);

    assign deq        = m_valid & m_ready;
    assign m_last     = m_valid && (dlv_q == len_q - LW'(1));
    assign req        = (state_q == REQ);
    assign req_len    = len_q;
    assign busy       = (state_q != IDLE);
    assign inflight_d = fifo_rd_en;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        len_d      = len_q;
        rem_d      = rem_q;
        dlv_d      = dlv_q;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ;
                    len_d   = launch_len;
                    rem_d   = launch_len;
                    timer_d = '0;
                end else if (fifo_empty) begin
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REQ: begin
                dlv_d = '0;
                if (gnt) state_d = XFER;
            end
            XFER: begin
                fifo_rd_en = (rem_q != '0) && (credit != 2'd0) && !fifo_empty;
                if (fifo_rd_en) rem_d = rem_q - LW'(1);
                if (deq) begin
                    dlv_d = dlv_q + LW'(1);
                    if (m_last) state_d = DONE;
                end
            end
            DONE: begin
                // Settle cycle: lets fifo_rd_count reflect the final pop.
                timer_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            dlv_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            dlv_q      <= dlv_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-based FIFO model feeds the drainer and a
// scoreboard of written words checks every delivered beat and burst timing.
module tb_fifo_burst_drain;
    import pci_fifo_pkg::*;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned ASIZE = 4;
    localparam int unsigned BM    = 8;
    localparam int unsigned TO    = 16;
    localparam int unsigned LW    = len_width(BM);

    logic             rd_clk = 1'b0;
    logic             rd_rst;
    logic [DSIZE-1:0] fifo_dout;
    logic             fifo_empty;
    logic [ASIZE:0]   fifo_rd_count;
    logic             fifo_rd_en;
    logic             flush;
    logic             req;
    logic [LW-1:0]    req_len;
    logic             gnt;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;

    always #5 rd_clk = ~rd_clk;

    fifo_burst_drain #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .BURST_MAX(BM), .TIMEOUT(TO)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
        .fifo_rd_en(fifo_rd_en), .flush(flush),
        .req(req), .req_len(req_len), .gnt(gnt),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy)
    );

    logic [DSIZE-1:0] fifo_q [$];   // words still inside the FIFO
    logic [DSIZE-1:0] exp_q  [$];   // words written and not yet delivered
    int n_cmp = 0;
    int n_mis = 0;
    int pops = 0;
    int delivered = 0;

    logic             s_rd_en, s_req, s_m_valid, s_m_last, s_busy, s_hs;
    logic [LW-1:0]    s_req_len;
    logic [DSIZE-1:0] s_m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_flags();
        fifo_empty    = (fifo_q.size() == 0);
        fifo_rd_count = (ASIZE + 1)'(fifo_q.size());
    endtask

    task automatic write_words(input logic [DSIZE-1:0] base, input int n, input bit rnd);
        logic [DSIZE-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DSIZE'($urandom) : base + DSIZE'(i);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        update_flags();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"},   fifo_rd_en, 1'b0);
        check({tag, "_req"},     req,        1'b0);
        check({tag, "_req_len"}, req_len,    '0);
        check({tag, "_m_data"},  m_data,     '0);
        check({tag, "_m_valid"}, m_valid,    1'b0);
        check({tag, "_m_last"},  m_last,     1'b0);
        check({tag, "_busy"},    busy,       1'b0);
    endtask

    // One clock cycle: sample on the falling edge, then serve the FIFO after the rising edge.
    task automatic tick();
        logic pop;
        @(negedge rd_clk);
        s_rd_en   = fifo_rd_en;
        s_req     = req;
        s_req_len = req_len;
        s_m_valid = m_valid;
        s_m_data  = m_data;
        s_m_last  = m_last;
        s_busy    = busy;
        s_hs      = m_valid & m_ready;
        pop       = fifo_rd_en;
        if (fifo_rd_en) begin
            check("pop_nonempty", fifo_empty, 1'b0);
            check("pop_window", ((pops - delivered - int'(s_hs)) < 2), 1'b1);
        end
        if (s_hs) begin
            check("beat_avail", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check("beat_data", m_data, exp_q.pop_front());
            delivered++;
        end
        @(posedge rd_clk);
        #1;
        if (pop && fifo_q.size() != 0) begin
            fifo_dout = fifo_q.pop_front();
            pops++;
        end
        update_flags();
    endtask

    // exp_delay counts ticks from the next tick until req is first seen.
    // mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
    task automatic run_burst(input int exp_len, input int exp_delay, input int mode,
                             input int flush_ticks, input int abort_after);
        int               t;
        int               k;
        int               beats;
        int               pops0;
        bit               seen_valid;
        logic             pv_stall;
        logic [DSIZE-1:0] pv_data;
        logic             pv_last;
        logic [LW-1:0]    len_seen;
        t     = 0;
        flush = (flush_ticks > 0);
        tick();
        while (!s_req && t < exp_delay + 8) begin
            t++;
            flush = (t < flush_ticks);
            tick();
        end
        flush = 1'b0;
        check("req_delay", t, exp_delay);
        check("req_len", s_req_len, exp_len);
        check("req_busy", s_busy, 1'b1);
        if (!s_req) return;
        len_seen = s_req_len;
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("req_hold", s_req, 1'b1);
            check("req_len_stable", s_req_len, len_seen);
        end
        gnt = 1'b1;
        tick();
        gnt        = 1'b0;
        pops0      = pops;
        beats      = 0;
        k          = 0;
        seen_valid = 1'b0;
        pv_stall   = 1'b0;
        pv_data    = '0;
        pv_last    = 1'b0;
        while (beats < exp_len && k < 200) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            tick();
            if (k == 1) begin
                check("rd_en_after_gnt", s_rd_en, 1'b1);
                check("req_drop", s_req, 1'b0);
            end
            if (pv_stall) begin
                check("stall_valid", s_m_valid, 1'b1);
                check("stall_data", s_m_data, pv_data);
                check("stall_last", s_m_last, pv_last);
            end
            if (seen_valid) begin
                check("no_gap", s_m_valid, 1'b1);
            end else if (s_m_valid) begin
                check("first_valid_lat", k, 3);
                seen_valid = 1'b1;
            end
            if (s_m_valid) check("last_flag", s_m_last, (beats == exp_len - 1));
            pv_stall = s_m_valid & ~s_hs;
            pv_data  = s_m_data;
            pv_last  = s_m_last;
            if (s_hs) beats++;
            if (abort_after != 0 && beats == abort_after) return;
        end
        m_ready = 1'b0;
        check("stream_beats", beats, exp_len);
        check("burst_pops", pops - pops0, exp_len);
        tick();
        check("done_busy", s_busy, 1'b1);
        check("done_req", s_req, 1'b0);
        check("done_valid", s_m_valid, 1'b0);
        tick();
        check("idle_busy", s_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit fl;
        rd_rst    = 1'b0;
        gnt       = 1'b0;
        flush     = 1'b0;
        m_ready   = 1'b0;
        fifo_dout = '0;
        update_flags();
        #1 rd_rst = 1'b1;
        #1 check_zero("reset");
        tick();
        tick();
        check_zero("reset_hold");
        rd_rst = 1'b0;

        // Full burst of 0x10..0x17 with the sink always ready.
        write_words(32'h10, 8, 1'b0);
        run_burst(8, 1, 0, 0, 0);

        // Three words only: launch waits for the idle timeout.
        write_words(32'h20, 3, 1'b0);
        run_burst(3, TO, 0, 0, 0);

        // Backpressure with ready 1,0,0 repeating.
        write_words('0, 8, 1'b1);
        run_burst(8, 1, 1, 0, 0);

        // One word plus a two-cycle flush pulse launches well before the timeout.
        write_words(32'h40, 1, 1'b0);
        run_burst(1, 1, 0, 2, 0);

        // Twelve words: a full burst, then a timed-out burst of the remaining four.
        write_words(32'h50, 12, 1'b0);
        run_burst(8, 1, 2, 0, 0);
        run_burst(4, TO - 1, 2, 0, 0);

        // Reset after three beats: outputs clear at once, undelivered pops are lost.
        write_words(32'h100, 8, 1'b0);
        run_burst(8, 1, 0, 0, 3);
        rd_rst = 1'b1;
        #1 check_zero("reset_mid");
        check("discard_bound", ((pops - delivered) <= 2), 1'b1);
        while (delivered < pops) begin
            exp_q.delete(0);
            delivered++;
        end
        m_ready = 1'b0;
        tick();
        tick();
        check_zero("reset_mid_hold");
        rd_rst = 1'b0;
        n = fifo_q.size();
        run_burst((n >= BM) ? BM : n, (n >= BM) ? 1 : TO, 0, 0, 0);

        // Random fill levels, optional flush, random backpressure.
        repeat (6) begin
            n  = $urandom_range(1, 14);
            fl = 1'($urandom_range(0, 1));
            write_words('0, n, 1'b1);
            run_burst((n >= BM) ? BM : n, (n >= BM || fl) ? 1 : TO, 2, fl ? 2 : 0, 0);
            if (n > BM) run_burst(n - BM, TO - 1, 2, 0, 0);
        end

        check("all_delivered", exp_q.size(), 0);
        check("fifo_drained", fifo_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
